// File: rtl/fb_scanout.sv
// fb_scanout: 640x480@60 VGA timing from a 50 MHz clock, scanning a 320x240 3-bit framebuffer
// through a 1-cycle synchronous-read port with 2x pixel doubling in x and y.
module fb_scanout #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SW   = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SW   = 2,
    parameter int V_BP   = 33,
    parameter int FB_W   = 320,
    parameter int ADDR_W = 17
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [2:0]        rd_data,
    output logic [9:0]        vga_r,
    output logic [9:0]        vga_g,
    output logic [9:0]        vga_b,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_blank_n,
    output logic              vga_sync_n,
    output logic              vga_clk,
    output logic              frame_start,
    output logic              vblank
);
    localparam logic [9:0] H_END   = 10'(H_VIS + H_FP + H_SW + H_BP - 1);
    localparam logic [9:0] V_END   = 10'(V_VIS + V_FP + V_SW + V_BP - 1);
    localparam logic [9:0] HS_BEG  = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END  = 10'(H_VIS + H_FP + H_SW - 1);
    localparam logic [9:0] VS_BEG  = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END  = 10'(V_VIS + V_FP + V_SW - 1);
    localparam logic [9:0] H_VIS_L = 10'(H_VIS);
    localparam logic [9:0] V_VIS_L = 10'(V_VIS);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t            r_state, w_state_nxt;
    logic              r_phase;
    logic [9:0]        r_h, r_v, w_h_nxt, w_v_nxt;
    logic              w_tick, w_eol, w_eof, w_vis, w_hs, w_vs, w_to_idle;
    logic [ADDR_W-1:0] w_row, w_col, w_addr, r_addr;
    logic              r_d_hs, r_d_vs, r_d_vis;
    logic              r_hs, r_vs, r_blank_n, r_frame_start, r_vblank;
    logic [2:0]        r_rgb;

    assign w_tick    = (r_state == S_RUN) && r_phase;
    assign w_eol     = r_h == H_END;
    assign w_eof     = w_eol && (r_v == V_END);
    assign w_vis     = (r_h < H_VIS_L) && (r_v < V_VIS_L);
    assign w_hs      = !((r_h >= HS_BEG) && (r_h <= HS_END));
    assign w_vs      = !((r_v >= VS_BEG) && (r_v <= VS_END));
    assign w_to_idle = (r_state == S_RUN) && (w_state_nxt == S_IDLE);
    assign w_row     = ADDR_W'(r_v[9:1]);
    assign w_col     = ADDR_W'(r_h[9:1]);

    // Row stride of 320 = 256 + 64, so the address needs only shifts and adds.
    generate
        if (FB_W == 320) begin : g_shift
            assign w_addr = (w_row << 8) + (w_row << 6) + w_col;
        end else begin : g_generic
            assign w_addr = w_row * ADDR_W'(FB_W) + w_col;
        end
    endgenerate

    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        if (r_state == S_IDLE) begin
            w_state_nxt = enable ? S_RUN : S_IDLE;
        end else if (w_tick) begin
            w_h_nxt     = w_eol ? 10'd0 : r_h + 10'd1;
            w_v_nxt     = w_eof ? 10'd0 : (w_eol ? r_v + 10'd1 : r_v);
            w_state_nxt = (w_eof && !enable) ? S_IDLE : S_RUN;
        end
    end

    // Stage 1 issues the address and latches syncs for (h,v); stage 2 one tick later
    // drives the pins with rd_data, keeping colour and syncs aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_phase       <= 1'b0;
            r_h           <= '0;
            r_v           <= '0;
            r_addr        <= '0;
            r_d_hs        <= 1'b1;
            r_d_vs        <= 1'b1;
            r_d_vis       <= 1'b0;
            r_hs          <= 1'b1;
            r_vs          <= 1'b1;
            r_blank_n     <= 1'b0;
            r_rgb         <= '0;
            r_frame_start <= 1'b0;
            r_vblank      <= 1'b1;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= (r_state == S_RUN) ? ~r_phase : 1'b0;
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_frame_start <= w_tick && (r_h == 10'd0) && (r_v == 10'd0);
            r_vblank      <= (w_state_nxt == S_IDLE) || (w_v_nxt >= V_VIS_L);
            if (w_tick) begin
                if (w_vis) r_addr <= w_addr;
                r_d_hs    <= w_hs;
                r_d_vs    <= w_vs;
                r_d_vis   <= w_vis;
                r_hs      <= r_d_hs;
                r_vs      <= r_d_vs;
                r_blank_n <= r_d_vis;
                r_rgb     <= r_d_vis ? rd_data : 3'b000;
            end
            if (w_to_idle) begin
                r_d_hs    <= 1'b1;
                r_d_vs    <= 1'b1;
                r_d_vis   <= 1'b0;
                r_hs      <= 1'b1;
                r_vs      <= 1'b1;
                r_blank_n <= 1'b0;
                r_rgb     <= '0;
            end
        end
    end

    assign rd_addr     = r_addr;
    assign vga_r       = {10{r_rgb[2]}};
    assign vga_g       = {10{r_rgb[1]}};
    assign vga_b       = {10{r_rgb[0]}};
    assign vga_hs      = r_hs;
    assign vga_vs      = r_vs;
    assign vga_blank_n = r_blank_n;
    assign vga_sync_n  = 1'b0;
    assign vga_clk     = r_phase;
    assign frame_start = r_frame_start;
    assign vblank      = r_vblank;
endmodule

// File: tb/tb_fb_scanout.sv
// tb_fb_scanout: directed table-driven checks of fb_scanout at full VGA timing (first lines)
// and at a shrunken timing (whole frames, enable drop and restart).
module tb_fb_scanout;
    localparam int M_FS = 1, M_VB = 2, M_AD = 4, M_HS = 8, M_VS = 16, M_BN = 32, M_C = 64, M_CK = 128;
    localparam int M_ALL = 255;

    typedef struct packed {
        logic fs, vb;
        logic [16:0] addr;
        logic hs, vs, bn;
        logic [9:0] r, g, b;
        logic ck;
    } obs_t;

    typedef struct {
        int n;
        int m;
        int addr;
        bit hs, vs, bn;
        bit [2:0] rgb;
        bit fs, vb, ck;
    } vec_t;

    logic clk = 1'b0, reset = 1'b1, en_a = 1'b0, en_b = 1'b0;
    logic [2:0] rd_a, rd_b;
    logic [16:0] addr_a, addr_b;
    logic [9:0] r_a, g_a, b_a, r_b, g_b, b_b;
    logic hs_a, vs_a, bn_a, sn_a, ck_a, fs_a, vb_a;
    logic hs_b, vs_b, bn_b, sn_b, ck_b, fs_b, vb_b;
    obs_t oa, ob;
    int pass_cnt = 0, total = 0;

    always #5 clk = ~clk;

    // Synchronous-read framebuffer models: constant 101 for A, low address bits for B.
    always @(posedge clk) begin
        rd_a <= 3'b101;
        rd_b <= addr_b[2:0];
    end

    fb_scanout dut_a (
        .clk(clk), .reset(reset), .enable(en_a), .rd_addr(addr_a), .rd_data(rd_a),
        .vga_r(r_a), .vga_g(g_a), .vga_b(b_a), .vga_hs(hs_a), .vga_vs(vs_a),
        .vga_blank_n(bn_a), .vga_sync_n(sn_a), .vga_clk(ck_a), .frame_start(fs_a), .vblank(vb_a)
    );

    fb_scanout #(
        .H_VIS(16), .H_FP(2), .H_SW(4), .H_BP(2),
        .V_VIS(12), .V_FP(2), .V_SW(2), .V_BP(2)
    ) dut_b (
        .clk(clk), .reset(reset), .enable(en_b), .rd_addr(addr_b), .rd_data(rd_b),
        .vga_r(r_b), .vga_g(g_b), .vga_b(b_b), .vga_hs(hs_b), .vga_vs(vs_b),
        .vga_blank_n(bn_b), .vga_sync_n(sn_b), .vga_clk(ck_b), .frame_start(fs_b), .vblank(vb_b)
    );

    assign oa = {fs_a, vb_a, addr_a, hs_a, vs_a, bn_a, r_a, g_a, b_a, ck_a};
    assign ob = {fs_b, vb_b, addr_b, hs_b, vs_b, bn_b, r_b, g_b, b_b, ck_b};

    function automatic vec_t mkv(input int n, input int m, input int addr, input bit hs, input bit vs,
                                 input bit bn, input int rgb, input bit fs, input bit vb, input bit ck);
        vec_t v;
        v.n = n; v.m = m; v.addr = addr; v.hs = hs; v.vs = vs; v.bn = bn;
        v.rgb = rgb[2:0]; v.fs = fs; v.vb = vb; v.ck = ck;
        return v;
    endfunction

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic check(input string tag, input int n, input vec_t e, input obs_t o);
        string p;
        p = $sformatf("%s@%0d", tag, n);
        if ((e.m & M_FS) != 0) cmp({p, " frame_start"}, 32'(o.fs), 32'(e.fs));
        if ((e.m & M_VB) != 0) cmp({p, " vblank"}, 32'(o.vb), 32'(e.vb));
        if ((e.m & M_AD) != 0) cmp({p, " rd_addr"}, 32'(o.addr), e.addr);
        if ((e.m & M_HS) != 0) cmp({p, " hs"}, 32'(o.hs), 32'(e.hs));
        if ((e.m & M_VS) != 0) cmp({p, " vs"}, 32'(o.vs), 32'(e.vs));
        if ((e.m & M_BN) != 0) cmp({p, " blank_n"}, 32'(o.bn), 32'(e.bn));
        if ((e.m & M_CK) != 0) cmp({p, " vga_clk"}, 32'(o.ck), 32'(e.ck));
        if ((e.m & M_C) != 0) begin
            cmp({p, " r"}, 32'(o.r), e.rgb[2] ? 32'h3ff : 32'h0);
            cmp({p, " g"}, 32'(o.g), e.rgb[1] ? 32'h3ff : 32'h0);
            cmp({p, " b"}, 32'(o.b), e.rgb[0] ? 32'h3ff : 32'h0);
        end
    endtask

    // n counts falling edges since the one where frame_start was first seen high.
    task automatic run_table(input string tag, input bit sel, input vec_t t[$], inout int n);
        foreach (t[i]) begin
            while (n < t[i].n) begin
                @(negedge clk);
                n++;
            end
            check(tag, n, t[i], sel ? ob : oa);
        end
    endtask

    task automatic wait_fs(input string tag, input bit sel, output int n);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(sel ? ob.fs : oa.fs) && k < 5000);
        cmp({tag, " first frame_start"}, 32'(sel ? ob.fs : oa.fs), 1);
        n = 0;
    endtask

    initial begin
        vec_t ta[$], tb1[$], tb2[$];
        vec_t idle_v;
        int n, cnt;
        idle_v = mkv(0, M_ALL, 0, 1, 1, 0, 0, 0, 1, 0);
        // Full timing: pixel p issued at n=2p, shown on pins at n=2p+2 and 2p+3.
        ta.push_back(mkv(0,    M_ALL,             0,   1, 1, 0, 0, 1, 0, 0));
        ta.push_back(mkv(1,    M_ALL,             0,   1, 1, 0, 0, 0, 0, 1));
        ta.push_back(mkv(2,    M_ALL,             0,   1, 1, 1, 5, 0, 0, 0));
        ta.push_back(mkv(4,    M_AD | M_BN | M_C, 1,   1, 1, 1, 5, 0, 0, 0));
        ta.push_back(mkv(1278, M_AD | M_BN | M_C, 319, 1, 1, 1, 5, 0, 0, 0));
        ta.push_back(mkv(1280, M_AD | M_BN | M_C, 319, 1, 1, 1, 5, 0, 0, 0));
        ta.push_back(mkv(1281, M_BN | M_C | M_CK, 319, 1, 1, 1, 5, 0, 0, 1));
        ta.push_back(mkv(1282, M_AD | M_HS | M_BN | M_C, 319, 1, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(1313, M_HS,              0,   1, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(1314, M_HS | M_VS | M_BN | M_C, 0, 0, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(1505, M_HS,              0,   0, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(1506, M_HS,              0,   1, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(1600, M_FS | M_VB | M_AD | M_BN, 0, 1, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(1602, M_AD | M_BN | M_C, 0,   1, 1, 1, 5, 0, 0, 0));
        ta.push_back(mkv(2913, M_HS,              0,   1, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(2914, M_HS,              0,   0, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(3200, M_AD | M_BN,       320, 1, 1, 0, 0, 0, 0, 0));
        ta.push_back(mkv(3202, M_AD | M_BN | M_C, 320, 1, 1, 1, 5, 0, 0, 0));
        ta.push_back(mkv(3204, M_AD,              321, 1, 1, 1, 5, 0, 0, 0));
        // Small timing: 24 px/line, 18 lines/frame, hs low h 18..21, vs low v 14..15.
        tb1.push_back(mkv(0,   M_ALL,             0,    1, 1, 0, 0, 1, 0, 0));
        tb1.push_back(mkv(2,   M_AD | M_BN | M_C, 0,    1, 1, 1, 0, 0, 0, 0));
        tb1.push_back(mkv(6,   M_AD | M_BN | M_C, 1,    1, 1, 1, 1, 0, 0, 0));
        tb1.push_back(mkv(10,  M_AD | M_BN | M_C, 2,    1, 1, 1, 2, 0, 0, 0));
        tb1.push_back(mkv(34,  M_AD | M_HS | M_BN | M_C, 7, 1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(37,  M_HS,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(38,  M_HS,              0,    0, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(45,  M_HS,              0,    0, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(46,  M_HS,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(156, M_AD | M_BN | M_C, 323,  1, 1, 1, 2, 0, 0, 0));
        tb1.push_back(mkv(558, M_AD,              1607, 1, 1, 1, 0, 0, 0, 0));
        tb1.push_back(mkv(560, M_AD | M_BN | M_C, 1607, 1, 1, 1, 7, 0, 0, 0));
        tb1.push_back(mkv(573, M_VB,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(574, M_VB,              0,    1, 1, 0, 0, 0, 1, 0));
        tb1.push_back(mkv(673, M_VS,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(674, M_VS | M_BN,       0,    1, 0, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(769, M_VS,              0,    1, 0, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(770, M_VS,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(861, M_VB | M_FS,       0,    1, 1, 0, 0, 0, 1, 0));
        tb1.push_back(mkv(862, M_VB,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(863, M_FS,              0,    1, 1, 0, 0, 0, 0, 0));
        tb1.push_back(mkv(864, M_FS | M_AD,       0,    1, 1, 0, 0, 1, 0, 0));
        // Second frame after enable drops at v=5: completes, then idles.
        tb2.push_back(mkv(1424, M_BN | M_C,       0,    1, 1, 1, 7, 0, 0, 0));
        tb2.push_back(mkv(1725, M_VS | M_BN | M_VB | M_CK, 0, 1, 1, 0, 0, 0, 1, 1));
        tb2.push_back(mkv(1726, M_ALL,            1607, 1, 1, 0, 0, 0, 1, 0));
        tb2.push_back(mkv(1727, M_CK | M_FS,      0,    1, 1, 0, 0, 0, 1, 0));
        tb2.push_back(mkv(1728, M_FS,             0,    1, 1, 0, 0, 0, 1, 0));

        repeat (4) @(negedge clk);
        reset = 1'b0;
        en_a  = 1'b1;
        wait_fs("A", 1'b0, n);
        run_table("A", 1'b0, ta, n);
        cmp("A sync_n", 32'(sn_a), 0);

        reset = 1'b1;
        en_a  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("A reset", 0, idle_v, oa);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("A idle", 0, idle_v, oa);

        en_b = 1'b1;
        wait_fs("B", 1'b1, n);
        run_table("B", 1'b1, tb1, n);
        while (n < 1104) begin
            @(negedge clk);
            n++;
        end
        en_b = 1'b0;
        run_table("B", 1'b1, tb2, n);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            cnt += int'(ob.fs) + int'(ob.ck);
        end
        cmp("B idle activity", cnt, 0);

        en_b = 1'b1;
        repeat (2) @(negedge clk);
        cmp("B restart early frame_start", 32'(ob.fs), 0);
        @(negedge clk);
        cmp("B restart frame_start", 32'(ob.fs), 1);
        cmp("B restart rd_addr", 32'(ob.addr), 0);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
